// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus.
// The fetch stage (master) drives imem_addr. The memory (slave) returns
// imem_rdata together with imem_ready, which marks imem_rdata as valid
// for the current imem_addr.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// It keeps the PC/nPC pair for the delayed-branch scheme and follows the
// hazard unit's stall controls. A redirect that arrives while fetch is frozen
// is held until the next advance. Saturating stall and memory-wait counters
// are kept for debug.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   pc_enable             0 freezes PC/nPC
//   load_enable           0 holds the IF/ID register
//   branch_taken/_target  redirect request from decode
//   imem                  instruction-memory bus (master side)
//   pc, npc               current fetch PC and its delay-slot successor
//   if_id_instr/_pc/_valid  IF/ID register presented to decode
//   fetch_state           00 BOOT, 01 RUN, 10 STALL, 11 MEM_WAIT
//   stall_count           saturating count of cycles with pc_enable=0
//   memwait_count         saturating count of cycles with imem_ready=0
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pc_enable,
  input  logic              load_enable,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  fetch_stage_if.master     imem,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic [1:0]        fetch_state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  memwait_count
);

  typedef enum logic [1:0] {
    StBoot    = 2'b00,
    StRun     = 2'b01,
    StStall   = 2'b10,
    StMemWait = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pending_target_q, pending_target_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  memwait_cnt_q, memwait_cnt_d;

  logic              advance;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;

  assign advance  = pc_enable & imem.imem_ready & (state_q != StBoot);
  // A live branch_taken takes priority over a redirect latched during a stall.
  assign redirect        = branch_taken | pending_q;
  assign redirect_target = branch_taken ? branch_target : pending_target_q;

  always_comb begin
    pc_d             = pc_q;
    npc_d            = npc_q;
    pending_d        = pending_q;
    pending_target_d = pending_target_q;
    instr_d          = instr_q;
    if_id_pc_d       = if_id_pc_q;
    valid_d          = valid_q;
    stall_cnt_d      = stall_cnt_q;
    memwait_cnt_d    = memwait_cnt_q;
    state_d          = state_q;

    // PC/nPC: the branch lands after one delay-slot instruction.
    if (advance) begin
      pc_d      = npc_q;
      npc_d     = redirect ? redirect_target : npc_q + ADDR_W'(4);
      pending_d = 1'b0;
    end else if (branch_taken) begin
      pending_d        = 1'b1;
      pending_target_d = branch_target;
    end

    // IF/ID register; a missing instruction becomes a NOP bubble.
    if (state_q != StBoot && load_enable) begin
      if_id_pc_d = pc_q;
      if (imem.imem_ready) begin
        instr_d = imem.imem_rdata;
        valid_d = 1'b1;
      end else begin
        instr_d = '0;
        valid_d = 1'b0;
      end
    end

    if (state_q != StBoot) begin
      if (!pc_enable && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (!imem.imem_ready && memwait_cnt_q != '1) begin
        memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StBoot: state_d = StRun;
      StRun, StStall, StMemWait: begin
        if (!imem.imem_ready)  state_d = StMemWait;
        else if (!pc_enable)   state_d = StStall;
        else                   state_d = StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StBoot;
      pc_q             <= RESET_PC;
      npc_q            <= RESET_PC + ADDR_W'(4);
      pending_q        <= 1'b0;
      pending_target_q <= '0;
      instr_q          <= '0;
      if_id_pc_q       <= '0;
      valid_q          <= 1'b0;
      stall_cnt_q      <= '0;
      memwait_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      npc_q            <= npc_d;
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
      instr_q          <= instr_d;
      if_id_pc_q       <= if_id_pc_d;
      valid_q          <= valid_d;
      stall_cnt_q      <= stall_cnt_d;
      memwait_cnt_q    <= memwait_cnt_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign npc            = npc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_valid    = valid_q;
  assign fetch_state    = state_q;
  assign stall_count    = stall_cnt_q;
  assign memwait_count  = memwait_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory returns addr ^ 32'hDEAD_0000, so the
// expected instruction follows from the expected if_id_pc.
module tb_fetch_stage;
  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pc_enable = 1'b1;
  logic        load_enable = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        ready = 1'b1;
  logic [31:0] pc, npc, if_id_instr, if_id_pc;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
  logic [CW-1:0] stall_count, memwait_count;

  fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem_if ();
  assign imem_if.imem_rdata = imem_if.imem_addr ^ 32'hDEAD_0000;
  assign imem_if.imem_ready = ready;

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .CNT_W(CW), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_enable     (pc_enable),
    .load_enable   (load_enable),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_if.master),
    .pc            (pc),
    .npc           (npc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .fetch_state   (fetch_state),
    .stall_count   (stall_count),
    .memwait_count (memwait_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p, l, r, b;
    logic [31:0] t;
    logic [31:0] e_pc, e_npc, e_ifpc;
    logic        e_v;
    logic [1:0]  e_st;
    int          e_sc, e_mc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_npc,
                           input logic [31:0] e_ifpc, input logic e_v, input logic [1:0] e_st,
                           input int e_sc, input int e_mc);
    logic [31:0] e_instr;
    e_instr = e_v ? (e_ifpc ^ 32'hDEAD_0000) : 32'h0;
    check({tag, " pc"}, pc, e_pc);
    check({tag, " imem_addr"}, imem_if.imem_addr, e_pc);
    check({tag, " npc"}, npc, e_npc);
    check({tag, " if_id_pc"}, if_id_pc, e_ifpc);
    check({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_v});
    check({tag, " if_id_instr"}, if_id_instr, e_instr);
    check({tag, " state"}, {30'b0, fetch_state}, {30'b0, e_st});
    check({tag, " stall_count"}, {28'b0, stall_count}, 32'(e_sc));
    check({tag, " memwait_count"}, {28'b0, memwait_count}, 32'(e_mc));
  endtask

  initial begin
    //                p  l  r  b  target     pc       npc      ifpc   v  st   sc mc
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h0,   32'h4,   32'h0,  0, 2'd1, 0, 0}); // v0 boot
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h4,   32'h8,   32'h0,  1, 2'd1, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h8,   32'hC,   32'h4,  1, 2'd1, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 32'h0,   32'h8,   32'hC,   32'h4,  1, 2'd2, 1, 0}); // v3 stall
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'hC,   32'h10,  32'h8,  1, 2'd1, 1, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h10,  32'h14,  32'hC,  1, 2'd1, 1, 0});
    vecs.push_back('{1, 1, 1, 1, 32'h40,  32'h14,  32'h40,  32'h10, 1, 2'd1, 1, 0}); // v6 br
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h40,  32'h44,  32'h14, 1, 2'd1, 1, 0}); // slot
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h44,  32'h48,  32'h40, 1, 2'd1, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 32'h80,  32'h44,  32'h48,  32'h40, 1, 2'd2, 2, 0}); // v9
    vecs.push_back('{0, 0, 1, 0, 32'h0,   32'h44,  32'h48,  32'h40, 1, 2'd2, 3, 0});
    vecs.push_back('{0, 0, 1, 0, 32'h0,   32'h44,  32'h48,  32'h40, 1, 2'd2, 4, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h48,  32'h80,  32'h44, 1, 2'd1, 4, 0}); // v12
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h80,  32'h84,  32'h48, 1, 2'd1, 4, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h84,  32'h88,  32'h80, 1, 2'd1, 4, 0});
    vecs.push_back('{1, 1, 1, 1, 32'h20,  32'h88,  32'h20,  32'h84, 1, 2'd1, 4, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h20,  32'h24,  32'h88, 1, 2'd1, 4, 0});
    vecs.push_back('{1, 1, 0, 0, 32'h0,   32'h20,  32'h24,  32'h20, 0, 2'd3, 4, 1}); // v17
    vecs.push_back('{1, 1, 0, 0, 32'h0,   32'h20,  32'h24,  32'h20, 0, 2'd3, 4, 2});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h24,  32'h28,  32'h20, 1, 2'd1, 4, 2});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h28,  32'h2C,  32'h24, 1, 2'd1, 4, 2});
    vecs.push_back('{1, 0, 1, 0, 32'h0,   32'h2C,  32'h30,  32'h24, 1, 2'd1, 4, 2}); // v21
    vecs.push_back('{0, 1, 1, 0, 32'h0,   32'h2C,  32'h30,  32'h2C, 1, 2'd2, 5, 2});
    vecs.push_back('{0, 1, 0, 0, 32'h0,   32'h2C,  32'h30,  32'h2C, 0, 2'd3, 6, 3});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h30,  32'h34,  32'h2C, 1, 2'd1, 6, 3});
    vecs.push_back('{0, 1, 1, 1, 32'h100, 32'h30,  32'h34,  32'h30, 1, 2'd2, 7, 3}); // v25
    vecs.push_back('{0, 1, 1, 1, 32'h200, 32'h30,  32'h34,  32'h30, 1, 2'd2, 8, 3});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h34,  32'h200, 32'h30, 1, 2'd1, 8, 3});
    vecs.push_back('{1, 1, 1, 0, 32'h0,   32'h200, 32'h204, 32'h34, 1, 2'd1, 8, 3});

    #12 reset_n = 1'b1;
    #1 check_all("reset", 32'h0, 32'h4, 32'h0, 1'b0, 2'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      pc_enable     = vecs[i].p;
      load_enable   = vecs[i].l;
      ready         = vecs[i].r;
      branch_taken  = vecs[i].b;
      branch_target = vecs[i].t;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_npc, vecs[i].e_ifpc,
                vecs[i].e_v, vecs[i].e_st, vecs[i].e_sc, vecs[i].e_mc);
    end

    // Long stall with a latched branch: counter saturates at 15.
    pc_enable = 1'b0; load_enable = 1'b1; ready = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h300;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      branch_taken = 1'b0;
    end
    check("sat stall_count", {28'b0, stall_count}, 32'd15);
    check("sat state", {30'b0, fetch_state}, 32'd2);
    check("sat pc", pc, 32'h200);

    // Asynchronous reset mid-stall, well away from any clock edge.
    #2 reset_n = 1'b0;
    #1 check_all("async_rst", 32'h0, 32'h4, 32'h0, 1'b0, 2'd0, 0, 0);

    @(posedge clk);
    #1;
    pc_enable = 1'b1; load_enable = 1'b1; ready = 1'b1;
    reset_n = 1'b1;
    check_all("rel", 32'h0, 32'h4, 32'h0, 1'b0, 2'd0, 0, 0);
    @(posedge clk); #1;
    check_all("rel_boot", 32'h0, 32'h4, 32'h0, 1'b0, 2'd1, 0, 0);
    @(posedge clk); #1;
    check_all("rel_f0", 32'h4, 32'h8, 32'h0, 1'b1, 2'd1, 0, 0);
    @(posedge clk); #1;
    check_all("rel_f1", 32'h8, 32'hC, 32'h4, 1'b1, 2'd1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
